// File: rtl/digit_scan_driver_pkg.sv
// Shared constants and types for the multiplexed 4-digit 7-segment scan driver.
// Package: scan_pkg
//   NUM_DIGITS / NIBBLE_W / SEG_W : display geometry
//   DATA_W                        : width of the loadable hex value
//   seg7_t                        : segment code, bit order {g,f,e,d,c,b,a}
//   SEG_OFF                       : all segments dark, active-high sense
package scan_pkg;
    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned NIBBLE_W   = 4;
    localparam int unsigned SEG_W      = 7;
    localparam int unsigned DATA_W     = NUM_DIGITS * NIBBLE_W;

    typedef logic [SEG_W-1:0]    seg7_t;
    typedef logic [NIBBLE_W-1:0] nibble_t;

    localparam seg7_t SEG_OFF = '0;
endpackage

// File: rtl/digit_scan_driver_if.sv
// Load handshake between a value producer and digit_scan_driver.
//   load_valid : producer offers load_data
//   load_data  : 16-bit hex value, nibble i -> digit i
//   load_ready : driver can accept a value this cycle
// Modports: master = producer, slave = digit_scan_driver.
interface digit_scan_driver_if;
    import scan_pkg::*;

    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_ready;

    modport master (output load_valid, output load_data, input load_ready);
    modport slave  (input load_valid, input load_data, output load_ready);
endinterface

// File: rtl/digit_scan_driver_hex_to_seg7.sv
// Combinational hex nibble to 7-segment decoder.
//   nibble : hex digit 0..F
//   seg    : {g,f,e,d,c,b,a}, active-high; output polarity is applied by the caller
module hex_to_seg7
    import scan_pkg::*;
(
    input  nibble_t nibble,
    output seg7_t   seg
);
    always_comb begin
        seg = SEG_OFF;
        case (nibble)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
            default: seg = SEG_OFF;
        endcase
    end
endmodule

// File: rtl/digit_scan_driver.sv
// 4-digit multiplexed 7-segment driver strobed by a one-hot ring sequencer.
// A new value is captured into a shadow buffer via the load handshake and is
// copied to the active buffer only at the q3->q0 frame boundary, so a frame
// never shows a mix of old and new digits.
// Ports:
//   clk, reset  : rising-edge clock, synchronous active-high reset
//   phase       : one-hot digit strobe, bit i = sequencer output qi
//   load        : value handshake (slave modport)
//   an          : digit enables, active-low when AN_ACTIVE_LOW
//   seg         : {g,f,e,d,c,b,a}, active-low when SEG_ACTIVE_LOW
//   frame_done  : one-cycle pulse after a buffer swap
//   phase_err   : sticky flag, a non-one-hot phase was sampled
// Build option: define BLANK_LEADING_ZERO_EN to blank leading zero digits
// (digit 0 always shown, blanked digits keep their anode strobe).
module digit_scan_driver
    import scan_pkg::*;
#(
    parameter bit AN_ACTIVE_LOW  = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_DIGITS-1:0] phase,
    digit_scan_driver_if.slave    load,
    output logic [NUM_DIGITS-1:0] an,
    output seg7_t                 seg,
    output logic                  frame_done,
    output logic                  phase_err
);
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW ? '1 : '0;
    localparam seg7_t                 SEG_DARK = SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;

    logic [DATA_W-1:0]     active_q, active_d;
    logic [DATA_W-1:0]     shadow_q, shadow_d;
    logic                  pending_q, pending_d;
    logic [NUM_DIGITS-1:0] phase_prev_q, phase_prev_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    seg7_t                 seg_q, seg_d;
    logic                  frame_done_q, frame_done_d;
    logic                  phase_err_q, phase_err_d;

    logic                  transfer;
    logic                  swap;
    logic                  phase_onehot;
    logic [1:0]            digit_idx;
    nibble_t               digit_nibble;
    seg7_t                 dec_seg;
    logic                  blank;

    assign load.load_ready = !pending_q && !reset;

    // Buffer control: a swap needs pending set at the start of the cycle, so a
    // transfer landing on a boundary waits for the following boundary.
    always_comb begin
        transfer     = load.load_valid && !pending_q;
        swap         = pending_q && phase_prev_q[NUM_DIGITS-1] && phase[0];
        shadow_d     = transfer ? load.load_data : shadow_q;
        active_d     = swap ? shadow_q : active_q;
        pending_d    = pending_q;
        if (swap) begin
            pending_d = 1'b0;
        end else if (transfer) begin
            pending_d = 1'b1;
        end
        frame_done_d = swap;
        phase_prev_d = phase;
        phase_onehot = $onehot(phase);
        phase_err_d  = phase_err_q || !phase_onehot;
    end

    // Digit select decodes from active_d so the swap cycle already shows the new value.
    always_comb begin
        digit_idx = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (phase[i]) begin
                digit_idx = 2'(i);
            end
        end
        digit_nibble = active_d[{digit_idx, 2'b00} +: NIBBLE_W];
`ifdef BLANK_LEADING_ZERO_EN
        blank = (digit_idx != 2'd0) && ((active_d >> {digit_idx, 2'b00}) == '0);
`else
        blank = 1'b0;
`endif
    end

    hex_to_seg7 u_hex_to_seg7 (
        .nibble (digit_nibble),
        .seg    (dec_seg)
    );

    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_DARK;
        if (phase_onehot) begin
            an_d = AN_ACTIVE_LOW ? ~phase : phase;
            if (!blank) begin
                seg_d = SEG_ACTIVE_LOW ? ~dec_seg : dec_seg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active_q     <= '0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            phase_prev_q <= '0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_DARK;
            frame_done_q <= 1'b0;
            phase_err_q  <= 1'b0;
        end else begin
            active_q     <= active_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            phase_prev_q <= phase_prev_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_done_d;
            phase_err_q  <= phase_err_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_done = frame_done_q;
    assign phase_err  = phase_err_q;
endmodule

// File: tb/tb_digit_scan_driver.sv
// Self-checking bench for digit_scan_driver (both polarities active-low).
// A frame-level model tracks displayed/offered values and predicts outputs;
// directed literal checks pin the model to hand-computed values.
module tb_digit_scan_driver;
    import scan_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  phase = 4'b0000;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        frame_done;
    logic        phase_err;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    digit_scan_driver_if lif ();

    digit_scan_driver #(
        .AN_ACTIVE_LOW  (1'b1),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .phase      (phase),
        .load       (lif),
        .an         (an),
        .seg        (seg),
        .frame_done (frame_done),
        .phase_err  (phase_err)
    );

    always #5 clk = ~clk;

    // Standard active-high segment patterns, indexed by hex digit.
    logic [6:0] seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Model state: value on the display, value waiting, error flag, last phase.
    logic [15:0] m_shown, m_waiting;
    logic        m_has_waiting, m_err, m_started;
    logic [3:0]  m_last_phase;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_fd;

    initial m_started = 1'b0;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        int digit;
        int ones;
        logic [15:0] upper;
        m_started = 1'b1;
        if (reset) begin
            m_shown = 16'h0; m_waiting = 16'h0; m_has_waiting = 1'b0;
            m_err = 1'b0; m_last_phase = 4'b0000;
            e_an = 4'hF; e_seg = 7'h7F; e_fd = 1'b0;
        end else begin
            e_fd = 1'b0;
            if (m_has_waiting && m_last_phase == 4'b1000 && phase[0]) begin
                m_shown = m_waiting; m_has_waiting = 1'b0; e_fd = 1'b1;
            end else if (m_last_phase[3] && phase[0] && m_has_waiting) begin
                m_shown = m_waiting; m_has_waiting = 1'b0; e_fd = 1'b1;
            end else if (!m_has_waiting && lif.load_valid) begin
                m_waiting = lif.load_data; m_has_waiting = 1'b1;
            end
            ones = $countones(phase);
            if (ones != 1) begin
                m_err = 1'b1; e_an = 4'hF; e_seg = 7'h7F;
            end else begin
                digit = 0;
                for (int k = 0; k < 4; k++) if (phase[k]) digit = k;
                e_an  = ~phase;
                upper = m_shown >> (4 * digit);
                e_seg = ~seg_tbl[upper[3:0]];
`ifdef BLANK_LEADING_ZERO_EN
                if (digit > 0 && upper == 16'h0) e_seg = 7'h7F;
`endif
            end
            m_last_phase = phase;
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            check("an", {12'h0, an}, {12'h0, e_an});
            check("seg", {9'h0, seg}, {9'h0, e_seg});
            check("frame_done", {15'h0, frame_done}, {15'h0, e_fd});
            check("phase_err", {15'h0, phase_err}, {15'h0, m_err});
            check("load_ready", {15'h0, lif.load_ready}, {15'h0, !m_has_waiting && !reset});
        end
    end

    // One clock cycle: drive just after the falling edge, return at the next falling edge.
    task automatic cyc(input logic rst, input logic [3:0] ph, input logic v, input logic [15:0] d);
        #1;
        reset = rst; phase = ph; lif.load_valid = v; lif.load_data = d;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        lif.load_valid = 1'b0;
        lif.load_data  = 16'h0;

        // Reset held two cycles
        cyc(1, 4'b0000, 0, 16'h0);
        cyc(1, 4'b0000, 0, 16'h0);
        check("rst_an", {12'h0, an}, 16'h000F);
        check("rst_seg", {9'h0, seg}, 16'h007F);
        check("rst_err", {15'h0, phase_err}, 16'h0);
        check("rst_fd", {15'h0, frame_done}, 16'h0);
        cyc(0, 4'b0001, 0, 16'h0);
        check("ready_after_rst", {15'h0, lif.load_ready}, 16'h1);

        // Load 1234, swap at q3->q0
        cyc(0, 4'b0010, 1, 16'h1234);
        cyc(0, 4'b0100, 0, 16'h0);
        check("pending_ready", {15'h0, lif.load_ready}, 16'h0);
        cyc(0, 4'b1000, 0, 16'h0);
        cyc(0, 4'b0001, 0, 16'h0);
        check("swap_an", {12'h0, an}, 16'h000E);
        check("swap_seg4", {9'h0, seg}, 16'h0019);
        check("swap_fd", {15'h0, frame_done}, 16'h1);
        check("swap_ready", {15'h0, lif.load_ready}, 16'h1);
        cyc(0, 4'b0010, 0, 16'h0);
        check("d1_an", {12'h0, an}, 16'h000D);
        check("d1_seg3", {9'h0, seg}, 16'h0030);
        check("fd_pulse", {15'h0, frame_done}, 16'h0);

        // ABCD loaded, 5555 offered while pending is refused
        cyc(0, 4'b0100, 1, 16'hABCD);
        cyc(0, 4'b1000, 1, 16'h5555);
        check("busy_ready", {15'h0, lif.load_ready}, 16'h0);
        cyc(0, 4'b0001, 0, 16'h0);
        check("abcd_d0", {9'h0, seg}, 16'h0021);
        check("abcd_fd", {15'h0, frame_done}, 16'h1);
        cyc(0, 4'b0010, 0, 16'h0);
        check("abcd_d1", {9'h0, seg}, 16'h0046);
        cyc(0, 4'b0100, 0, 16'h0);
        check("abcd_d2", {9'h0, seg}, 16'h0003);
        cyc(0, 4'b1000, 0, 16'h0);
        check("abcd_d3", {9'h0, seg}, 16'h0008);

        // Illegal phase
        cyc(0, 4'b0011, 0, 16'h0);
        check("bad_an", {12'h0, an}, 16'h000F);
        check("bad_seg", {9'h0, seg}, 16'h007F);
        check("bad_err", {15'h0, phase_err}, 16'h1);
        cyc(0, 4'b0001, 0, 16'h0);
        check("err_sticky", {15'h0, phase_err}, 16'h1);
        check("after_bad_an", {12'h0, an}, 16'h000E);
        cyc(0, 4'b0000, 0, 16'h0);
        check("zero_phase_an", {12'h0, an}, 16'h000F);

        // Value 0005: leading-zero behaviour
        cyc(0, 4'b0010, 1, 16'h0005);
        cyc(0, 4'b0100, 0, 16'h0);
        cyc(0, 4'b1000, 0, 16'h0);
        cyc(0, 4'b0001, 0, 16'h0);
        check("z5_d0", {9'h0, seg}, 16'h0012);
        cyc(0, 4'b0010, 0, 16'h0);
`ifdef BLANK_LEADING_ZERO_EN
        check("z5_d1", {9'h0, seg}, 16'h007F);
        check("z5_d1_an", {12'h0, an}, 16'h000D);
`else
        check("z5_d1", {9'h0, seg}, 16'h0040);
`endif
        cyc(0, 4'b0100, 0, 16'h0);
        cyc(0, 4'b1000, 0, 16'h0);
`ifdef BLANK_LEADING_ZERO_EN
        check("z5_d3", {9'h0, seg}, 16'h007F);
`else
        check("z5_d3", {9'h0, seg}, 16'h0040);
`endif

        // Reset while a value is pending discards it
        cyc(0, 4'b0001, 0, 16'h0);
        cyc(0, 4'b0010, 1, 16'h9999);
        cyc(1, 4'b0100, 0, 16'h0);
        check("rst2_err", {15'h0, phase_err}, 16'h0);
        cyc(0, 4'b1000, 0, 16'h0);
        check("rst2_ready", {15'h0, lif.load_ready}, 16'h1);
        cyc(0, 4'b0001, 0, 16'h0);
        check("rst2_seg0", {9'h0, seg}, 16'h0040);
        check("rst2_fd", {15'h0, frame_done}, 16'h0);
        cyc(0, 4'b0010, 0, 16'h0);
        cyc(0, 4'b0100, 0, 16'h0);
        cyc(0, 4'b1000, 0, 16'h0);
        cyc(0, 4'b0001, 0, 16'h0);
        check("rst2_no_swap", {15'h0, frame_done}, 16'h0);

        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
